// File: rtl/shift_reg_pkg.sv
// Shared constants, state encoding and lane-count helper for the frame shifter.
package shift_reg_pkg;

  localparam logic [1:0] SHIFT_REG_MODE_X1 = 2'd0;
  localparam logic [1:0] SHIFT_REG_MODE_X2 = 2'd1;
  localparam logic [1:0] SHIFT_REG_MODE_X4 = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_reg_xfer_state_e;

  // Modes the build cannot support (or the reserved code) fall back to one lane.
  function automatic logic [2:0] shift_reg_lanes(input logic [1:0] mode, input int unsigned lane_num);
    logic [2:0] lanes;
    lanes = 3'd1;
    if (mode == SHIFT_REG_MODE_X2 && lane_num >= 2) lanes = 3'd2;
    if (mode == SHIFT_REG_MODE_X4 && lane_num >= 4) lanes = 3'd4;
    return lanes;
  endfunction

endpackage

// File: rtl/shift_reg_align.sv
// Right-justifies and masks the received frame bits out of the shift register image.
module shift_reg_align
  import shift_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [LEN_WIDTH:0]    bits,
  input  logic                  lsb_first,
  output logic [DATA_WIDTH-1:0] data_c
);

  localparam int unsigned BW = LEN_WIDTH + 1;

  logic [BW-1:0] pad;

  // LSB-first frames land in the top bits; MSB-first frames land in the bottom bits.
  always_comb begin
    pad = BW'(DATA_WIDTH) - bits;
    if (lsb_first) data_c = data >> pad;
    else           data_c = data & ({DATA_WIDTH{1'b1}} >> pad);
  end

endmodule

// File: rtl/shift_reg_xfer.sv
// Multi-lane full-duplex frame shifter: parallel load, serial shift out/in, parallel return.
module shift_reg_xfer
  import shift_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE_NUM   = 4,
  parameter int unsigned LEN_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            mode_i,
  input  logic                  lsb_first_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  sft_en_i,
  input  logic                  abort_i,
  input  logic                  par_valid_i,
  output logic                  par_ready_o,
  input  logic [DATA_WIDTH-1:0] par_data_i,
  output logic                  par_valid_o,
  input  logic                  par_ready_i,
  output logic [DATA_WIDTH-1:0] par_data_o,
  input  logic [LANE_NUM-1:0]   ser_dat_i,
  output logic [LANE_NUM-1:0]   ser_dat_o,
  output logic                  ser_oe_o,
  output logic                  busy_o
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned BW = LEN_WIDTH + 1;

  shift_reg_xfer_state_e state_q, state_d;

  logic [DW-1:0] sr_q, sr_d, sr_shift, rx_aligned, par_data_q, par_data_d;
  logic [BW-1:0] cnt_q, cnt_d, bits_q, bits_d, beats_q, beats_d;
  logic [BW-1:0] len_ext, bits_in, beats_in;
  logic [2:0]    lanes_q, lanes_d, lanes_in;
  logic          lsb_q, lsb_d;
  logic          par_ready_q, par_ready_d, par_valid_q, par_valid_d;
  logic          ser_oe_q, ser_oe_d, busy_q, busy_d;
  logic [3:0]    din4, dout4;

  // Frame geometry from the live configuration inputs, captured on acceptance.
  always_comb begin
    len_ext  = BW'(len_i);
    lanes_in = shift_reg_lanes(mode_i, LANE_NUM);
    case (lanes_in)
      3'd2: begin
        bits_in  = (len_ext | BW'(1)) + BW'(1);
        beats_in = bits_in >> 1;
      end
      3'd4: begin
        bits_in  = (len_ext | BW'(3)) + BW'(1);
        beats_in = bits_in >> 2;
      end
      default: begin
        bits_in  = len_ext + BW'(1);
        beats_in = bits_in;
      end
    endcase
  end

  // Current transmit beat and the register image after one beat.
  always_comb begin
    din4     = 4'(ser_dat_i);
    dout4    = '0;
    sr_shift = sr_q;
    case ({lsb_q, lanes_q})
      {1'b0, 3'd2}: begin
        dout4    = {2'b00, sr_q[DW-1 -: 2]};
        sr_shift = {sr_q[DW-3:0], din4[1:0]};
      end
      {1'b0, 3'd4}: begin
        dout4    = sr_q[DW-1 -: 4];
        sr_shift = {sr_q[DW-5:0], din4};
      end
      {1'b1, 3'd1}: begin
        dout4    = {3'b000, sr_q[0]};
        sr_shift = {din4[0], sr_q[DW-1:1]};
      end
      {1'b1, 3'd2}: begin
        dout4    = {2'b00, sr_q[1:0]};
        sr_shift = {din4[1:0], sr_q[DW-1:2]};
      end
      {1'b1, 3'd4}: begin
        dout4    = sr_q[3:0];
        sr_shift = {din4, sr_q[DW-1:4]};
      end
      default: begin
        dout4    = {3'b000, sr_q[DW-1]};
        sr_shift = {sr_q[DW-2:0], din4[0]};
      end
    endcase
  end

  shift_reg_align #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_align (
    .data     (sr_shift),
    .bits     (bits_q),
    .lsb_first(lsb_q),
    .data_c   (rx_aligned)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    bits_d     = bits_q;
    beats_d    = beats_q;
    lanes_d    = lanes_q;
    lsb_d      = lsb_q;
    par_data_d = par_data_q;
    case (state_q)
      IDLE: begin
        if (par_valid_i && !abort_i) begin
          state_d = SHIFT;
          sr_d    = par_data_i;
          cnt_d   = '0;
          lanes_d = lanes_in;
          lsb_d   = lsb_first_i;
          bits_d  = bits_in;
          beats_d = beats_in;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d    = IDLE;
          cnt_d      = '0;
          par_data_d = '0;
        end else if (sft_en_i) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + BW'(1);
          if (cnt_q == beats_q - BW'(1)) begin
            state_d    = DONE;
            par_data_d = rx_aligned;
          end
        end
      end
      DONE: begin
        if (abort_i) begin
          state_d    = IDLE;
          par_data_d = '0;
        end else if (par_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    par_ready_d = (state_d == IDLE);
    par_valid_d = (state_d == DONE);
    ser_oe_d    = (state_d == SHIFT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      bits_q      <= '0;
      beats_q     <= '0;
      lanes_q     <= 3'd1;
      lsb_q       <= 1'b0;
      par_data_q  <= '0;
      par_ready_q <= 1'b1;
      par_valid_q <= 1'b0;
      ser_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      beats_q     <= beats_d;
      lanes_q     <= lanes_d;
      lsb_q       <= lsb_d;
      par_data_q  <= par_data_d;
      par_ready_q <= par_ready_d;
      par_valid_q <= par_valid_d;
      ser_oe_q    <= ser_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign par_ready_o = par_ready_q;
  assign par_valid_o = par_valid_q;
  assign par_data_o  = par_data_q;
  assign ser_oe_o    = ser_oe_q;
  assign busy_o      = busy_q;
  assign ser_dat_o   = ser_oe_q ? LANE_NUM'(dout4) : '0;

endmodule

// File: tb/tb_shift_reg_xfer.sv
// Scoreboarded random/directed bench for shift_reg_xfer (8-bit, 4-lane build plus a 1-lane build).
module tb_shift_reg_xfer;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 4;
  localparam int SRC_RAND = 0;
  localparam int SRC_LOOP = 1;
  localparam int SRC_WORD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, lsb_first_i, sft_en_i, abort_i;
  logic [1:0]    mode_i;
  logic [2:0]    len_i;
  logic          par_valid_i, par_ready_o, par_valid_o, par_ready_i;
  logic [DW-1:0] par_data_i, par_data_o;
  logic [LN-1:0] ser_dat_i, ser_dat_o;
  logic          ser_oe_o, busy_o;

  shift_reg_xfer #(.DATA_WIDTH(DW), .LANE_NUM(LN)) dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .lsb_first_i(lsb_first_i), .len_i(len_i),
    .sft_en_i(sft_en_i), .abort_i(abort_i), .par_valid_i(par_valid_i), .par_ready_o(par_ready_o),
    .par_data_i(par_data_i), .par_valid_o(par_valid_o), .par_ready_i(par_ready_i),
    .par_data_o(par_data_o), .ser_dat_i(ser_dat_i), .ser_dat_o(ser_dat_o),
    .ser_oe_o(ser_oe_o), .busy_o(busy_o)
  );

  // Single-lane build, serial output looped back to its input.
  logic          n1_par_valid_i, n1_par_ready_o, n1_par_valid_o, n1_par_ready_i, n1_sft_en_i;
  logic          n1_ser_oe_o, n1_busy_o;
  logic [DW-1:0] n1_par_data_i, n1_par_data_o;
  logic [0:0]    n1_ser_dat_o;

  shift_reg_xfer #(.DATA_WIDTH(DW), .LANE_NUM(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .mode_i(2'd2), .lsb_first_i(1'b0), .len_i(3'd7),
    .sft_en_i(n1_sft_en_i), .abort_i(1'b0), .par_valid_i(n1_par_valid_i), .par_ready_o(n1_par_ready_o),
    .par_data_i(n1_par_data_i), .par_valid_o(n1_par_valid_o), .par_ready_i(n1_par_ready_i),
    .par_data_o(n1_par_data_o), .ser_dat_i(n1_ser_dat_o), .ser_dat_o(n1_ser_dat_o),
    .ser_oe_o(n1_ser_oe_o), .busy_o(n1_busy_o)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0]    tx_q[$];
  logic [DW-1:0] rx_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int model_lanes(int mode, int lane_num);
    if (mode == 1 && lane_num >= 2) return 2;
    if (mode == 2 && lane_num >= 4) return 4;
    return 1;
  endfunction

  // Monitor: serial beats and returned words against the scoreboard queues.
  always @(negedge clk) begin
    if (ser_oe_o) begin
      if (tx_q.size() == 0) check("ser_unexpected", 32'(ser_oe_o), 32'd0);
      else begin
        check("ser_dat", 32'(ser_dat_o), 32'(tx_q[0]));
        if (sft_en_i) void'(tx_q.pop_front());
      end
    end else begin
      check("ser_idle", 32'(ser_dat_o), 32'd0);
    end
    if (par_valid_o) begin
      if (rx_q.size() == 0) check("rx_unexpected", 32'(par_valid_o), 32'd0);
      else begin
        check("par_data", 32'(par_data_o), 32'(rx_q[0]));
        if (par_ready_i) void'(rx_q.pop_front());
      end
    end
  end

  task automatic idle_outputs(string tag);
    check({tag, "_ready"}, 32'(par_ready_o), 32'd1);
    check({tag, "_valid"}, 32'(par_valid_o), 32'd0);
    check({tag, "_oe"},    32'(ser_oe_o),    32'd0);
    check({tag, "_busy"},  32'(busy_o),      32'd0);
    check({tag, "_ser"},   32'(ser_dat_o),   32'd0);
    check({tag, "_data"},  32'(par_data_o),  32'd0);
  endtask

  task automatic run_frame(input logic [7:0] tx, input int mode, input bit lsb, input int len,
                           input int rx_src, input logic [31:0] rx_word,
                           input int stall_at, input int stall_len, input int bp,
                           input int abort_at, input int rst_at,
                           input bit expect_first, input bit hold_end);
    int l, b, nb, tries, exp_rx, m, txb, rxb;
    bit acc;
    l  = model_lanes(mode, LN);
    b  = ((len + 1 + l - 1) / l) * l;
    nb = b / l;
    m  = (1 << l) - 1;
    par_valid_i = 1'b1; par_data_i = tx; mode_i = 2'(mode); lsb_first_i = lsb; len_i = 3'(len);
    par_ready_i = 1'b0;
    tries = 0; acc = 1'b0;
    while (!acc && tries < 50) begin
      acc = par_ready_o;
      @(posedge clk); #1;
      tries++;
    end
    check("accept", 32'(acc), 32'd1);
    if (expect_first) check("b2b_accept_cycles", 32'(tries), 32'd1);
    par_valid_i = 1'b0;
    mode_i = 2'($urandom); lsb_first_i = 1'($urandom); len_i = 3'($urandom); par_data_i = 8'($urandom);
    if (!acc) return;
    exp_rx = 0;
    for (int k = 0; k < nb; k++) begin
      txb = lsb ? ((int'(tx) >> (k * l)) & m) : ((int'(tx) >> (DW - (k + 1) * l)) & m);
      tx_q.push_back(4'(txb));
      case (rx_src)
        SRC_LOOP: rxb = txb;
        SRC_WORD: rxb = int'(rx_word >> (4 * k)) & m;
        default:  rxb = int'($urandom) & m;
      endcase
      ser_dat_i = 4'(rxb) | (4'($urandom) & ~4'(m));
      if (k == abort_at) begin
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        tx_q.delete();
        idle_outputs("abort");
        return;
      end
      if (k == rst_at) begin
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        tx_q.delete();
        idle_outputs("midrst");
        return;
      end
      if (k == stall_at) repeat (stall_len) begin @(posedge clk); #1; end
      sft_en_i = 1'b1;
      @(posedge clk); #1;
      sft_en_i = 1'b0;
      if (lsb) exp_rx = exp_rx | (rxb << (k * l));
      else     exp_rx = (exp_rx << l) | rxb;
    end
    rx_q.push_back(8'(exp_rx));
    check("valid_latency", 32'(par_valid_o), 32'd1);
    check("done_oe", 32'(ser_oe_o), 32'd0);
    par_valid_i = (bp > 0);
    repeat (bp) begin
      par_data_i = 8'($urandom);
      check("done_ready", 32'(par_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    par_valid_i = hold_end;
    par_ready_i = 1'b1;
    @(posedge clk); #1;
    par_ready_i = 1'b0;
    check("post_hs_valid", 32'(par_valid_o), 32'd0);
    check("post_hs_ready", 32'(par_ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, mode, len, ab;
    logic [7:0] tx1;
    rst_i = 1'b1; mode_i = '0; lsb_first_i = 1'b0; len_i = '0; sft_en_i = 1'b0; abort_i = 1'b0;
    par_valid_i = 1'b0; par_ready_i = 1'b0; par_data_i = '0; ser_dat_i = '0;
    n1_par_valid_i = 1'b0; n1_par_ready_i = 1'b0; n1_sft_en_i = 1'b0; n1_par_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    idle_outputs("reset");
    rst_i = 1'b0;
    @(posedge clk); #1;

    run_frame(8'hA5, 0, 1'b0, 7, SRC_LOOP, 32'h0,    -1, 0, 0, -1, -1, 1'b0, 1'b0);
    run_frame(8'h0C, 0, 1'b1, 3, SRC_WORD, 32'h1001, -1, 0, 0, -1, -1, 1'b0, 1'b0);
    run_frame(8'h3C, 2, 1'b0, 7, SRC_WORD, 32'h17,    1, 5, 4, -1, -1, 1'b0, 1'b0);
    run_frame(8'h5A, 0, 1'b0, 7, SRC_RAND, 32'h0,    -1, 0, 0,  3, -1, 1'b0, 1'b0);
    run_frame(8'h5A, 0, 1'b0, 7, SRC_RAND, 32'h0,    -1, 0, 0, -1,  3, 1'b0, 1'b0);
    run_frame(8'h96, 1, 1'b1, 5, SRC_RAND, 32'h0,     2, 3, 2, -1, -1, 1'b0, 1'b1);
    run_frame(8'h01, 2, 1'b0, 0, SRC_RAND, 32'h0,    -1, 0, 1, -1, -1, 1'b1, 1'b0);
    run_frame(8'hF0, 3, 1'b1, 7, SRC_RAND, 32'h0,    -1, 0, 0, -1, -1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 3));
      len  = int'($urandom_range(0, 7));
      ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_frame(8'($urandom), mode, 1'($urandom), len, SRC_RAND, 32'h0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                ab, -1, 1'b0, 1'b0);
    end

    tx1 = 8'($urandom);
    n1_par_data_i = tx1; n1_par_valid_i = 1'b1;
    @(posedge clk); #1;
    n1_par_valid_i = 1'b0;
    check("n1_busy", 32'(n1_busy_o), 32'd1);
    n1_sft_en_i = 1'b1;
    beats = 0;
    while (!n1_par_valid_o && beats < 30) begin
      @(posedge clk); #1;
      beats++;
    end
    n1_sft_en_i = 1'b0;
    check("n1_beats", 32'(beats), 32'd8);
    check("n1_data", 32'(n1_par_data_o), 32'(tx1));
    n1_par_ready_i = 1'b1;
    @(posedge clk); #1;
    n1_par_ready_i = 1'b0;
    check("n1_post_valid", 32'(n1_par_valid_o), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
